// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, sync polarity constants and test-pattern encodings.
package vga_pkg;

   // 640x480@60 from a 252 MHz system clock
   localparam int DEF_CLK_DIV    = 10;
   localparam int DEF_H_ACTIVE   = 640;
   localparam int DEF_H_FP       = 16;
   localparam int DEF_H_SYNC     = 96;
   localparam int DEF_H_BP       = 48;
   localparam int DEF_V_ACTIVE   = 480;
   localparam int DEF_V_FP       = 10;
   localparam int DEF_V_SYNC     = 2;
   localparam int DEF_V_BP       = 33;
   localparam int DEF_CW         = 11;
   localparam int DEF_CHECK_LOG2 = 4;

   localparam bit POL_ACTIVE_LOW  = 1'b0;
   localparam bit POL_ACTIVE_HIGH = 1'b1;

   typedef enum logic [1:0] {
      PAT_BLACK = 2'd0,
      PAT_CHECK = 2'd1,
      PAT_BARS  = 2'd2,
      PAT_WHITE = 2'd3
   } pattern_e;

endpackage

// File: rtl/vga_axis.sv
// Generic wrapping position counter for one VGA axis, with active/sync decode
// of the current count and a wrap strobe for cascading into the next axis.
module vga_axis #(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int CW     = 11
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_step,
   output logic [CW-1:0] o_cnt,
   output logic          o_active,
   output logic          o_sync,
   output logic          o_wrap
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_step)
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
   end

   assign o_cnt    = r_cnt;
   assign o_active = (r_cnt < CW'(ACTIVE));
   assign o_sync   = (r_cnt >= SYNC_LO) && (r_cnt < SYNC_HI);
   assign o_wrap   = i_step && (r_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Single-clock VGA timing and test-pattern generator: a pixel clock-enable drives
// cascaded axis counters, and all outputs are registered together on that enable.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit HSYNC_POL  = POL_ACTIVE_LOW,
   parameter bit VSYNC_POL  = POL_ACTIVE_LOW,
   parameter int CW         = DEF_CW,
   parameter int CHECK_LOG2 = DEF_CHECK_LOG2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [1:0]    pattern_sel,
   output logic          pix_ce,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          frame_start,
   output logic          line_start,
   output logic [2:0]    rgb
);

   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BAR_W = H_ACTIVE / 8;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

   logic [DW-1:0] r_div_cnt;
   logic          w_tick;
   logic [CW-1:0] w_hcnt, w_vcnt;
   logic          w_h_active, w_h_sync, w_h_wrap;
   logic          w_v_active, w_v_sync, w_v_wrap;
   logic          r_at_origin;
   logic [CW-1:0] r_bar_sub;
   logic [2:0]    r_bar_idx;
   pattern_e      r_pat_q;
   pattern_e      w_pat;
   logic [2:0]    w_rgb;

   logic          r_pix_ce, r_hsync, r_vsync, r_de, r_frame_start, r_line_start;
   logic [CW-1:0] r_x, r_y;
   logic [2:0]    r_rgb;

   assign w_tick = en && (r_div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_div_cnt <= '0;
      else if (en)
         r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
   end

   vga_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_axis (
      .i_clk(clk), .i_rst_n(rst_n), .i_step(w_tick),
      .o_cnt(w_hcnt), .o_active(w_h_active), .o_sync(w_h_sync), .o_wrap(w_h_wrap)
   );

   vga_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_axis (
      .i_clk(clk), .i_rst_n(rst_n), .i_step(w_h_wrap),
      .o_cnt(w_vcnt), .o_active(w_v_active), .o_sync(w_v_sync), .o_wrap(w_v_wrap)
   );

   // Origin flag and bar position track the counters, so they describe the current (hcnt,vcnt)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_at_origin <= 1'b1;
         r_bar_sub   <= '0;
         r_bar_idx   <= '0;
      end else if (w_tick) begin
         r_at_origin <= w_v_wrap;
         if (w_h_wrap) begin
            r_bar_sub <= '0;
            r_bar_idx <= '0;
         end else if (r_bar_sub == BAR_LAST) begin
            r_bar_sub <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
         end else begin
            r_bar_sub <= r_bar_sub + CW'(1);
         end
      end
   end

   // The pixel at the origin already uses the newly selected pattern
   always_comb begin
      w_pat = r_at_origin ? pattern_e'(pattern_sel) : r_pat_q;
      w_rgb = 3'b000;
      case (w_pat)
         PAT_CHECK: w_rgb = {w_hcnt[CHECK_LOG2] ^ w_vcnt[CHECK_LOG2], 2'b00};
         PAT_BARS:  w_rgb = ~r_bar_idx;
         PAT_WHITE: w_rgb = 3'b111;
         default:   w_rgb = 3'b000;
      endcase
      if (!(w_h_active && w_v_active))
         w_rgb = 3'b000;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pix_ce      <= 1'b0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_de          <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_rgb         <= 3'b000;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
         r_pat_q       <= PAT_BLACK;
      end else begin
         r_pix_ce      <= w_tick;
         r_frame_start <= w_tick && r_at_origin;
         r_line_start  <= w_tick && (w_hcnt == '0);
         if (w_tick) begin
            r_x     <= w_hcnt;
            r_y     <= w_vcnt;
            r_de    <= w_h_active && w_v_active;
            r_hsync <= w_h_sync ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_v_sync ? VSYNC_POL : ~VSYNC_POL;
            r_rgb   <= w_rgb;
            if (r_at_origin)
               r_pat_q <= w_pat;
         end
      end
   end

   assign pix_ce      = r_pix_ce;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign x           = r_x;
   assign y           = r_y;
   assign frame_start = r_frame_start;
   assign line_start  = r_line_start;
   assign rgb         = r_rgb;

endmodule
